avg_filter: RTL and testbench

Streaming moving-average (noise) filter for 24-bit signed audio samples. Sits directly upstream of the 24-bit output sample register. Each accepted input updates a running sum of the last N samples, each pre-scaled by 1/N. `dout` and `out_valid` drive that register's `D` and `en` inputs. Throughput is one sample per clock; latency is one cycle.

---
 rtl/avg_pkg.sv | 9 +
 rtl/sample_fifo.sv | 65 ++++++
 rtl/avg_filter.sv | 97 +++++++++
 tb/tb_avg_filter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/avg_pkg.sv
// Shared constants and sample type for the moving-average filter.
package avg_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int AVG_LOG2N = 3;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage : avg_pkg

// File: rtl/sample_fifo.sv
// Depth 2^LOG2N window FIFO with simultaneous push/pop.
// The head is read from registered storage, so it is stable for the whole
// cycle and reflects the state left by the previous edge.
module sample_fifo
    import avg_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int LOG2N = AVG_LOG2N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << LOG2N;
    localparam logic [LOG2N-1:0] PTR_ONE = LOG2N'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [LOG2N-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2N-1:0] rd_ptr_q, rd_ptr_d;

    assign rdata = mem_q[rd_ptr_q];

    // Next-state for storage and pointers; pointers wrap modulo DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule : sample_fifo

// File: rtl/avg_filter.sv
// Streaming N-sample moving average of signed samples. Each sample is
// pre-scaled by 1/N (arithmetic shift), so the running sum of the window
// never exceeds the sample range and needs no saturation.
module avg_filter
    import avg_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int LOG2N = AVG_LOG2N
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] din,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] dout,
    output logic                    full
);

    localparam logic [LOG2N:0] FILL_MAX = {1'b1, {LOG2N{1'b0}}};
    localparam logic [LOG2N:0] FILL_ONE = (LOG2N + 1)'(1);

    logic signed [WIDTH-1:0] scaled_s;
    logic signed [WIDTH-1:0] oldest_s;
    logic [WIDTH-1:0]        head_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    win_full_s;

    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic [LOG2N:0]          fill_q, fill_d;
    logic                    out_valid_q, out_valid_d;
    logic                    full_q, full_d;

    assign scaled_s   = din >>> LOG2N;
    assign win_full_s = (fill_q == FILL_MAX);
    assign oldest_s   = win_full_s ? $signed(head_s) : '0;

    sample_fifo #(
        .WIDTH (WIDTH),
        .LOG2N (LOG2N)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (scaled_s),
        .rdata (head_s)
    );

    // Accept/flush decision and running-sum update; clear beats in_valid.
    always_comb begin
        acc_d       = acc_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (clear) begin
            acc_d  = '0;
            fill_d = '0;
        end else if (in_valid) begin
            push_s      = 1'b1;
            pop_s       = win_full_s;
            acc_d       = acc_q + scaled_s - oldest_s;
            out_valid_d = 1'b1;
            if (win_full_s) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + FILL_ONE;
            end
        end else begin
            acc_d = acc_q;
        end
        full_d = (fill_d == FILL_MAX);
    end

    // Output and window-state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            full_q      <= full_d;
        end
    end

    assign dout      = acc_q;
    assign out_valid = out_valid_q;
    assign full      = full_q;

endmodule : avg_filter

// File: tb/tb_avg_filter.sv
// Scoreboard bench for avg_filter: the reference model keeps the last N
// scaled samples and sums them from scratch for every accepted sample.
module tb_avg_filter;
    import avg_pkg::*;

    typedef struct {
        longint dout;
        longint full;
    } exp_t;

    logic           clk;
    logic           reset;
    logic           clear;
    logic           in_valid;
    sample_t        din;
    logic           out_valid;
    sample_t        dout;
    logic           full;

    int     n_checks;
    int     n_fail;
    int     ov_count;
    exp_t   exp_q[$];
    longint win_q[$];
    longint last_exp;
    exp_t   mon_e;

    avg_filter dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .din       (din),
        .out_valid (out_valid),
        .dout      (dout),
        .full      (full)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        win_q.delete();
        exp_q.delete();
        last_exp = 0;
    endtask

    // Drive one sample and push its expected result to the scoreboard.
    task automatic send(input sample_t s);
        longint sum;
        exp_t   e;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b1;
        din      = s;
        win_q.push_back(longint'(s) >>> 3);
        if (win_q.size() > 8) void'(win_q.pop_front());
        sum = 0;
        foreach (win_q[i]) sum += win_q[i];
        e.dout   = sum;
        e.full   = (win_q.size() == 8) ? 1 : 0;
        last_exp = sum;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            clear    = 1'b0;
        end
    endtask

    // Scoreboard monitor: compare every output pulse against the queue head.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            ov_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("dout", dout, mon_e.dout);
                check("full", full, mon_e.full);
            end
        end
    end

    initial begin
        int ov_before;
        n_checks = 0;
        n_fail   = 0;
        ov_count = 0;
        last_exp = 0;
        reset    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        din      = '0;

        // Reset state
        #1;
        check("rst_dout", dout, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_full", full, 0);
        idle(2);
        reset = 1'b1;
        idle(1);

        // Fill: 8 x 800 -> 100..800, full after the eighth
        for (int i = 0; i < 8; i++) send(24'sd800);
        idle(1);
        check("fill_final_dout", dout, 800);
        check("fill_full", full, 1);

        // Steady-state replace with zeros
        for (int i = 0; i < 8; i++) send(24'sd0);
        idle(1);
        check("zeros_dout", dout, 0);

        // Negative and extreme values
        for (int i = 0; i < 8; i++) send(-24'sd8);
        idle(1);
        check("neg8_dout", dout, -8);
        for (int i = 0; i < 8; i++) send(24'sh7FFFFF);
        idle(1);
        check("max_dout", dout, 24'sh7FFFF8);

        // Gapped input from a fresh window, including floor of -1
        reset = 1'b0;
        model_flush();
        idle(1);
        reset = 1'b1;
        idle(1);
        ov_before = ov_count;
        send(-24'sd1);
        idle(1);
        check("floor_neg1", dout, -1);
        for (int k = 0; k < 5; k++) begin
            send(sample_t'($urandom_range(0, 2000)) - 24'sd1000);
            idle(1);
            for (int g = 0; g < 3; g++) begin
                @(negedge clk);
                check("gap_hold", dout, last_exp);
                check("gap_no_valid", out_valid, 0);
            end
        end
        check("gap_pulse_count", ov_count - ov_before, 6);

        // Reset mid-run, asserted between edges while out_valid is high
        reset = 1'b0;
        model_flush();
        idle(1);
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) send(24'sd800);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_flush();
        #1;
        check("midrst_dout", dout, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_full", full, 0);
        in_valid = 1'b0;
        idle(1);
        reset = 1'b1;
        send(24'sd800);
        idle(1);
        check("after_rst_dout", dout, 100);

        // Clear collision on a full window
        for (int i = 0; i < 7; i++) send(24'sd800);
        idle(1);
        check("pre_clear_full", full, 1);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        din      = 24'sd800;
        model_flush();
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_dout", dout, 0);
        check("clear_out_valid", out_valid, 0);
        check("clear_full", full, 0);
        send(24'sd800);
        idle(2);
        check("after_clear_dout", dout, 100);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_avg_filter
